fpga_carry_chain: RTL and testbench
===================================

FPGA_CARRY_CHAIN -- requirements
Module: fpga_carry_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SEG_W, default 4, bits per pipelined carry segment; WIDTH SHALL be a multiple of SEG_W (elaboration error otherwise).
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  operand beat present.
REQ-006 ready_o  output  1  chain can accept a beat this cycle.
REQ-007 mode_i  input  2  operation select, per beat.
REQ-008 a_i, b_i  input  WIDTH  operands.
REQ-009 cin_i  input  1  carry-in.
REQ-010 valid_o  output  1  result beat present.
REQ-011 ready_i  input  1  downstream accepts result.
REQ-012 sum_o  output  WIDTH  result.
REQ-013 cout_o  output  1  carry out of MSB.
REQ-014 ovf_o  output  1  signed overflow flag.

Function
REQ-015 Modes SHALL be: 00 ADD = a+b+cin; 01 SUB = a+~b+1 (cin ignored); 10 SUBB = a+~b+cin; 11 INC = a+cin (b ignored).
REQ-016 NSEG = WIDTH/SEG_W stages; stage k SHALL compute bits [k*SEG_W +: SEG_W] using the registered carry from stage k-1 (stage 0 uses effective cin).
REQ-017 Operands SHALL be skew-delayed into each stage and lower result bits deskewed, so all bits of one beat leave together.
REQ-018 Latency SHALL be exactly NSEG cycles from the accepting edge (valid_i && ready_o) to valid_o, with no stall.
REQ-019 Advance condition: adv = ready_i || !valid_o; ready_o = adv; all stages move only when adv=1.
REQ-020 While valid_o && !ready_i, sum_o/cout_o/ovf_o/valid_o SHALL hold stable; no beat lost or duplicated; order preserved.
REQ-021 Full throughput: one beat per cycle when ready_i is held high.
REQ-022 Bubbles (valid_i=0 on an advancing cycle) SHALL propagate as invalid stages; data in invalid stages is don't-care.
REQ-023 cout_o SHALL be the raw carry out of the MSB (for SUB, 1 means no borrow).
REQ-024 ovf_o SHALL be carry-into-MSB XOR carry-out-of-MSB.

Reset
REQ-025 On rst_i=1 at a clock edge: all stage valid bits, valid_o, sum_o, cout_o, ovf_o SHALL be 0 next cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after reset.
REQ-027 ready_o SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro FPGA_CARRY_CHAIN_OVF_EN: defined -> overflow logic and its pipeline bit present, ovf_o per REQ-024; undefined -> no overflow logic, ovf_o tied 0.

Structure
REQ-029 Shared package fpga_carry_pkg SHALL hold the mode enum (ADD, SUB, SUBB, INC) and an NSEG helper function.
REQ-030 Per-segment ripple logic plus carry/valid register SHALL be sub-module fpga_carry_segment (parameter SEG_W), instantiated NSEG times via generate.

Verification (WIDTH=16, SEG_W=4, latency 4)
REQ-031 ADD a=0xFFFF b=0x0001 cin=0 -> 4 cycles later sum_o=0x0000, cout_o=1, ovf_o=0.
REQ-032 SUB a=0x8000 b=0x0001 -> sum_o=0x7FFF, cout_o=1, ovf_o=1 (ovf_o=0 with macro undefined).
REQ-033 INC a=0x7FFF cin=1 -> sum_o=0x8000, cout_o=0, ovf_o=1; SUBB a=0x0000 b=0x0000 cin=0 -> sum_o=0xFFFF, cout_o=0.
REQ-034 8 back-to-back random beats, ready_i low for 3 cycles mid-stream -> outputs held stable while stalled, all 8 results match model, in order, none duplicated.
REQ-035 rst_i pulsed one cycle with 2 beats in flight -> valid_o=0 the cycle after, no stale result ever appears, next beat after reset returns correctly after 4 cycles.

Source files
------------

// File: rtl/fpga_carry_pkg.sv
// Shared types and helpers for the segmented, pipelined carry chain.
// Holds the per-beat operation encoding and the stage-count helper.
package fpga_carry_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        SUBB = 2'b10,
        INC  = 2'b11
    } mode_e;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/fpga_carry_segment.sv
// One ripple segment of the chain: combinational SEG_W-bit add with a
// registered carry-out and valid bit that advance only when adv_i is high.
module fpga_carry_segment
    import fpga_carry_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             valid_o,
    output logic             cout_o
);

    logic [SEG_W:0] total;
    logic           valid_reg;
    logic           carry_reg;

    always_comb begin
        total = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
    end

    assign sum_o = total[SEG_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
        end else if (adv_i) begin
            valid_reg <= valid_i;
            carry_reg <= total[SEG_W];
        end
    end

    assign valid_o = valid_reg;
    assign cout_o  = carry_reg;

endmodule

// File: rtl/fpga_carry_chain.sv
// Pipelined WIDTH-bit adder/subtractor split into SEG_W-bit carry segments.
// Optional signed-overflow flag: define FPGA_CARRY_CHAIN_OVF_EN.
module fpga_carry_chain
    import fpga_carry_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if ((SEG_W < 1) || ((WIDTH % SEG_W) != 0)) begin : g_bad_cfg
        $error("fpga_carry_chain: WIDTH must be a positive multiple of SEG_W");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             in_valid_reg;
    logic             in_carry_reg;
    logic [NSEG-1:0]  seg_valid;
    logic [NSEG-1:0]  seg_cout;

    // Subtraction is folded into the add by inverting b; INC drops b entirely.
    always_comb begin
        b_eff   = b_i;
        cin_eff = cin_i;
        case (mode_e'(mode_i))
            ADD:  begin b_eff = b_i;         cin_eff = cin_i; end
            SUB:  begin b_eff = ~b_i;        cin_eff = 1'b1;  end
            SUBB: begin b_eff = ~b_i;        cin_eff = cin_i; end
            INC:  begin b_eff = '0;          cin_eff = cin_i; end
            default: begin b_eff = b_i;      cin_eff = cin_i; end
        endcase
    end

    assign valid_o = seg_valid[NSEG-1];
    assign adv     = ready_i || !valid_o;
    assign ready_o = adv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_valid_reg <= 1'b0;
            in_carry_reg <= 1'b0;
        end else if (adv) begin
            in_valid_reg <= valid_i;
            in_carry_reg <= cin_eff;
        end
    end

    // Stage gi keeps only the operand bits not yet consumed (skew) and the
    // result bits already produced (deskew), so widths shrink/grow per stage.
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int OW = WIDTH - gi * SEG_W;
        localparam int RW = (gi + 1) * SEG_W;

        logic [OW-1:0]    a_sk_reg;
        logic [OW-1:0]    b_sk_reg;
        logic [SEG_W-1:0] seg_sum;
        logic [RW-1:0]    res_reg;
        logic             seg_vin;
        logic             seg_cin;

        if (gi == 0) begin : g_head
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_sk_reg <= '0;
                    b_sk_reg <= '0;
                    res_reg  <= '0;
                end else if (adv) begin
                    a_sk_reg <= a_i;
                    b_sk_reg <= b_eff;
                    res_reg  <= seg_sum;
                end
            end
            assign seg_vin = in_valid_reg;
            assign seg_cin = in_carry_reg;
        end else begin : g_tail
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_sk_reg <= '0;
                    b_sk_reg <= '0;
                    res_reg  <= '0;
                end else if (adv) begin
                    a_sk_reg <= g_stage[gi-1].a_sk_reg[OW+SEG_W-1:SEG_W];
                    b_sk_reg <= g_stage[gi-1].b_sk_reg[OW+SEG_W-1:SEG_W];
                    res_reg  <= {seg_sum, g_stage[gi-1].res_reg};
                end
            end
            assign seg_vin = seg_valid[gi-1];
            assign seg_cin = seg_cout[gi-1];
        end

        fpga_carry_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .adv_i  (adv),
            .valid_i(seg_vin),
            .a_i    (a_sk_reg[SEG_W-1:0]),
            .b_i    (b_sk_reg[SEG_W-1:0]),
            .cin_i  (seg_cin),
            .sum_o  (seg_sum),
            .valid_o(seg_valid[gi]),
            .cout_o (seg_cout[gi])
        );
    end

    assign sum_o  = g_stage[NSEG-1].res_reg;
    assign cout_o = seg_cout[NSEG-1];

`ifdef FPGA_CARRY_CHAIN_OVF_EN
    // Carry into the word MSB is recovered from the MSB sum bit and registered
    // alongside the final carry; overflow is their XOR.
    logic cmsb_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmsb_reg <= 1'b0;
        end else if (adv) begin
            cmsb_reg <= g_stage[NSEG-1].a_sk_reg[SEG_W-1]
                      ^ g_stage[NSEG-1].b_sk_reg[SEG_W-1]
                      ^ g_stage[NSEG-1].seg_sum[SEG_W-1];
        end
    end

    assign ovf_o = cmsb_reg ^ cout_o;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_carry_chain.sv
// Self-checking bench for fpga_carry_chain: directed vector table, streaming
// with backpressure, random traffic and mid-flight reset.
module tb_fpga_carry_chain;

    localparam int W    = 16;
    localparam int SW   = 4;
    localparam int NSEG = W / SW;
`ifdef FPGA_CARRY_CHAIN_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [1:0]   mode_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    always #5 clk = ~clk;

    fpga_carry_chain #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .mode_i (mode_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .sum_o  (sum_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        string        name;
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_in  = 0;
    bit   was_stalled = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: true integer arithmetic; carry = unsigned result exceeds the
    // word, overflow = signed result outside the representable range.
    function automatic res_t model(input logic [1:0] m, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c);
        res_t   r;
        longint span = longint'(1) << W;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = a[W-1] ? ua - span : ua;
        longint sb   = b[W-1] ? ub - span : ub;
        longint ci   = longint'(c);
        longint u;
        longint s;
        case (m)
            2'd0:    begin u = ua + ub + ci;               s = sa + sb + ci;          end
            2'd1:    begin u = ua - ub + span;             s = sa - sb;               end
            2'd2:    begin u = ua - ub - 1 + ci + span;    s = sa - sb - 1 + ci;      end
            default: begin u = ua + ci;                    s = sa + ci;               end
        endcase
        r.sum  = u[W-1:0];
        r.cout = u[W];
        r.ovf  = OVF_ON && ((s > (span / 2) - 1) || (s < -(span / 2)));
        return r;
    endfunction

    // Scoreboard: evaluated mid-cycle, describing what the next edge will do.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            was_stalled = 1'b0;
        end else begin
            if (was_stalled)
                check("stall_hold_valid", W'(valid_o), W'(1));
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", W'(valid_o), W'(0));
                end else begin
                    check("sb_sum",  sum_o,       exp_q[0].sum);
                    check("sb_cout", W'(cout_o),  W'(exp_q[0].cout));
                    check("sb_ovf",  W'(ovf_o),   W'(exp_q[0].ovf));
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            was_stalled = valid_o && !ready_i;
            if (valid_i && ready_o) begin
                exp_q.push_back(model(mode_i, a_i, b_i, cin_i));
                n_in++;
            end
        end
    end

    // Issues one beat (caller is just after a clock edge), then measures the
    // edges until valid_o and checks the result against the vector.
    task automatic run_single(input vec_t v);
        int lat;
        mode_i  = v.mode;
        a_i     = v.a;
        b_i     = v.b;
        cin_i   = v.cin;
        valid_i = 1'b1;
        @(negedge clk);
        check({v.name, "_ready"}, W'(ready_o), W'(1));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 3 * NSEG) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, "_latency"}, W'(lat), W'(NSEG));
        check({v.name, "_sum"},  sum_o,      v.sum);
        check({v.name, "_cout"}, W'(cout_o), W'(v.cout));
        check({v.name, "_ovf"},  W'(ovf_o),  W'(v.ovf && OVF_ON));
        $display("vec %-12s mode=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 v.name, v.mode, v.a, v.b, v.cin, sum_o, cout_o, ovf_o, lat);
    endtask

    task automatic drain(input string name, input int n_expected, input int n_start);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drained"}, W'(exp_q.size()), W'(0));
        check({name, "_count"}, W'(n_out - n_start), W'(n_expected));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[10];

    initial begin
        int n0;
        int i0;
        vec_t v;

        vt[0] = '{"add_wrap",  2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{"sub_ovf",   2'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vt[2] = '{"inc_ovf",   2'd3, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{"subb_zero", 2'd2, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vt[4] = '{"add_cin",   2'd0, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};
        vt[5] = '{"sub_cin1",  2'd1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[6] = '{"sub_small", 2'd1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
        vt[7] = '{"inc_wrap",  2'd3, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8] = '{"subb_ovf",  2'd2, 16'h8000, 16'h0001, 1'b0, 16'h7FFE, 1'b1, 1'b1};
        vt[9] = '{"add_ovf",   2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_i   = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        mode_i  = 2'd0;
        a_i     = 16'hA5A5;
        b_i     = 16'h5A5A;
        cin_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_sum",   sum_o,       W'(0));
        check("rst_cout",  W'(cout_o),  W'(0));
        check("rst_ovf",   W'(ovf_o),   W'(0));
        rst_i   = 1'b0;
        valid_i = 1'b0;
        check("rst_ready", W'(ready_o), W'(1));
        $display("reset: valid_o=%0d sum_o=%h ready_o=%0d", valid_o, sum_o, ready_o);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_single(vt[i]);
        drain("table", 10, n_out - 10 + exp_q.size());

        // Eight back-to-back random beats with a 3-cycle downstream stall.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bit acc;
                    mode_i  = 2'($urandom);
                    a_i     = W'($urandom);
                    b_i     = W'($urandom);
                    cin_i   = 1'($urandom);
                    valid_i = 1'b1;
                    do begin
                        @(negedge clk);
                        acc = ready_o;
                        @(posedge clk);
                        #1;
                    end while (!acc);
                    $display("stream beat %0d mode=%0d a=%h b=%h cin=%0d", i, mode_i, a_i, b_i, cin_i);
                end
                valid_i = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain("stream", 8, n0);

        // Random valid/ready traffic.
        n0 = n_out;
        i0 = n_in;
        for (int c = 0; c < 300; c++) begin
            valid_i = 1'($urandom);
            mode_i  = 2'($urandom);
            a_i     = W'($urandom);
            b_i     = W'($urandom);
            cin_i   = 1'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain("random", n_in - i0, n0);
        $display("random: %0d beats in, %0d results out", n_in - i0, n_out - n0);

        // Reset with two beats in flight.
        mode_i  = 2'd0;
        a_i     = 16'h1111;
        b_i     = 16'h2222;
        cin_i   = 1'b0;
        valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("midrst_valid", W'(valid_o), W'(0));
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", W'(valid_o), W'(0));
        end
        $display("mid-flight reset: no stale results over 8 cycles");
        v = '{"post_rst", 2'd1, 16'h4000, 16'h0001, 1'b1, 16'h3FFF, 1'b1, 1'b0};
        run_single(v);

        // Reset while a result is held at the output under backpressure.
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        v = '{"held_rst", 2'd0, 16'h9000, 16'h9000, 1'b0, 16'h2000, 1'b1, 1'b1};
        run_single(v);
        repeat (2) @(posedge clk);
        #1;
        check("held_sum", sum_o, 16'h2000);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        check("heldrst_valid", W'(valid_o), W'(0));
        check("heldrst_sum",   sum_o,       W'(0));
        check("heldrst_cout",  W'(cout_o),  W'(0));
        check("heldrst_ovf",   W'(ovf_o),   W'(0));
        check("heldrst_ready", W'(ready_o), W'(1));
        $display("held reset: valid_o=%0d sum_o=%h cout_o=%0d", valid_o, sum_o, cout_o);
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
